// File: rtl/btn_gen_pkg.sv
// Shared definitions for the button press generator: FSM states, button levels, helpers.
package btn_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PB,
        ST_HOLD,
        ST_RB,
        ST_GAP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic PRESS_LEVEL = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_seg_timer.sv
// Loadable down-counter; tc is high during the last cycle of a loaded interval.
module btn_seg_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // A value V loaded on state entry yields exactly V cycles in that state.
    assign tc = (count_reg == W'(1));

endmodule

// File: rtl/btn_press_gen.sv
// Turns a press command into an active-low button waveform with optional contact bounce.
module btn_press_gen
    import btn_gen_pkg::*;
#(
    parameter int HOLD_W     = 16,
    parameter int BOUNCE_CYC = 16,
    parameter int BOUNCE_N   = 3,
    parameter int GAP_CYC    = 512
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              cmd_bounce,
    output logic              btn,
    output logic              busy,
    output logic              done,
    output logic [7:0]        press_cnt
);

    localparam int SEG_W    = $clog2(max_int(BOUNCE_CYC, GAP_CYC) + 1);
    localparam int SEG_LAST = (BOUNCE_N > 0) ? 2 * BOUNCE_N - 1 : 0;
    localparam int IDX_W    = (SEG_LAST > 0) ? $clog2(SEG_LAST + 1) : 1;

    localparam logic [SEG_W-1:0] BOUNCE_LOAD = SEG_W'(BOUNCE_CYC);
    localparam logic [SEG_W-1:0] GAP_LOAD    = SEG_W'(GAP_CYC);

    state_t             state_reg;
    logic               btn_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [7:0]         press_cnt_reg;
    logic [HOLD_W-1:0]  hold_reg;
    logic               bounce_reg;
    logic [IDX_W-1:0]   idx_reg;

    logic               accept;
    logic               bounce_cmd;
    logic               idx_last;
    logic [HOLD_W-1:0]  hold_eff_cmd;
    logic [HOLD_W-1:0]  hold_eff_reg;
    logic               seg_load;
    logic [SEG_W-1:0]   seg_val;
    logic               seg_tc;
    logic               hold_load;
    logic [HOLD_W-1:0]  hold_val;
    logic               hold_tc;

    assign cmd_ready    = (state_reg == ST_IDLE);
    assign accept       = cmd_valid && cmd_ready;
    assign bounce_cmd   = cmd_bounce && (BOUNCE_N > 0);
    assign idx_last     = (idx_reg == IDX_W'(SEG_LAST));
    assign hold_eff_cmd = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
    assign hold_eff_reg = (hold_reg == '0) ? HOLD_W'(1) : hold_reg;

    // Timer loads mirror the FSM transitions so each count starts on state entry.
    always_comb begin
        seg_load  = 1'b0;
        seg_val   = BOUNCE_LOAD;
        hold_load = 1'b0;
        hold_val  = hold_eff_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (bounce_cmd) begin
                        seg_load = 1'b1;
                    end else begin
                        hold_load = 1'b1;
                        hold_val  = hold_eff_cmd;
                    end
                end
            end
            ST_PB: begin
                if (seg_tc) begin
                    if (idx_last) hold_load = 1'b1;
                    else          seg_load  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_tc) begin
                    seg_load = 1'b1;
                    seg_val  = bounce_reg ? BOUNCE_LOAD : GAP_LOAD;
                end
            end
            ST_RB: begin
                if (seg_tc) begin
                    seg_load = 1'b1;
                    seg_val  = idx_last ? GAP_LOAD : BOUNCE_LOAD;
                end
            end
            default: ;
        endcase
    end

    btn_seg_timer #(.W(SEG_W)) u_seg_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (seg_load),
        .load_val (seg_val),
        .tc       (seg_tc)
    );

    btn_seg_timer #(.W(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (hold_load),
        .load_val (hold_val),
        .tc       (hold_tc)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            btn_reg       <= IDLE_LEVEL;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            press_cnt_reg <= 8'd0;
            hold_reg      <= '0;
            bounce_reg    <= 1'b0;
            idx_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        hold_reg   <= cmd_hold;
                        bounce_reg <= bounce_cmd;
                        busy_reg   <= 1'b1;
                        btn_reg    <= PRESS_LEVEL;
                        idx_reg    <= '0;
                        state_reg  <= bounce_cmd ? ST_PB : ST_HOLD;
                    end
                end
                ST_PB: begin
                    if (seg_tc) begin
                        if (idx_last) begin
                            btn_reg   <= PRESS_LEVEL;
                            state_reg <= ST_HOLD;
                        end else begin
                            btn_reg <= ~btn_reg;
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_tc) begin
                        btn_reg   <= IDLE_LEVEL;
                        idx_reg   <= '0;
                        state_reg <= bounce_reg ? ST_RB : ST_GAP;
                    end
                end
                ST_RB: begin
                    if (seg_tc) begin
                        if (idx_last) begin
                            btn_reg   <= IDLE_LEVEL;
                            state_reg <= ST_GAP;
                        end else begin
                            btn_reg <= ~btn_reg;
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (seg_tc) begin
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        press_cnt_reg <= press_cnt_reg + 8'd1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign btn       = btn_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign press_cnt = press_cnt_reg;

endmodule

// File: tb/tb_btn_press_gen.sv
// Directed bench for btn_press_gen, including a behavioural key debouncer on btn.
module tb_btn_press_gen;

    localparam int HOLD_W = 16;
    localparam int BC     = 16;
    localparam int BN     = 3;
    localparam int GAP    = 260;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_bounce = 1'b0;
    logic [HOLD_W-1:0] cmd_hold = '0;
    logic              cmd_ready;
    logic              btn;
    logic              busy;
    logic              done;
    logic [7:0]        press_cnt;

    int pass_cnt = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    btn_press_gen #(
        .HOLD_W     (HOLD_W),
        .BOUNCE_CYC (BC),
        .BOUNCE_N   (BN),
        .GAP_CYC    (GAP)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_hold   (cmd_hold),
        .cmd_bounce (cmd_bounce),
        .btn        (btn),
        .busy       (busy),
        .done       (done),
        .press_cnt  (press_cnt)
    );

    // Key debouncer: level must differ for 256 consecutive cycles to be taken.
    logic       db_clr = 1'b1;
    logic       db_state;
    logic [7:0] db_cnt;
    int         led;

    always @(posedge clk) begin
        if (db_clr) begin
            db_state <= 1'b1;
            db_cnt   <= 8'd0;
            led      <= 0;
        end else if (btn != db_state) begin
            if (db_cnt == 8'd255) begin
                db_state <= btn;
                db_cnt   <= 8'd0;
                if (btn == 1'b0) led <= led + 1;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end else begin
            db_cnt <= 8'd0;
        end
    end

    typedef struct {
        int   total;
        int   low;
        int   max_run;
        int   short_runs;
        int   falls_early;
        int   falls_late;
        int   done_cnt;
        logic ready_at_issue;
        logic first_btn;
        logic first_busy;
        logic first_ready;
        logic done_busy;
        logic done_after;
    } meas_t;

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Issues one command and measures the waveform from the first btn change to done.
    task automatic run_press(input int hold, input bit bounce, output meas_t m);
        int t;
        int run;
        logic prev;
        int hmax;
        int early_lim;
        m = '{default: 0};
        hmax = (hold == 0) ? 1 : hold;
        early_lim = bounce ? 2 * BN * BC + hmax : hmax;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_hold = HOLD_W'(hold);
        cmd_bounce = bounce;
        m.ready_at_issue = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_hold = HOLD_W'(7);
        cmd_bounce = ~bounce;
        m.first_btn = btn;
        m.first_busy = busy;
        m.first_ready = cmd_ready;
        t = 0;
        run = 0;
        prev = 1'b1;
        m.total = -1;
        while (t < 6000) begin
            if (done === 1'b1) begin
                m.total = t;
                m.done_busy = busy;
                m.done_cnt = int'(press_cnt);
                break;
            end
            if (btn === 1'b0) begin
                m.low++;
                run++;
                if (prev === 1'b1) begin
                    if (t < early_lim) m.falls_early++;
                    else               m.falls_late++;
                end
            end else if (run > 0) begin
                if (run > m.max_run) m.max_run = run;
                if (run == BC) m.short_runs++;
                run = 0;
            end
            prev = btn;
            t++;
            @(negedge clk);
        end
        @(negedge clk);
        m.done_after = done;
        $display("press hold=%0d bounce=%0d change_to_done=%0d low=%0d falls=%0d+%0d cnt=%0d",
                 hold, bounce, m.total, m.low, m.falls_early, m.falls_late, m.done_cnt);
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_cnt++; if (btn !== 1'b1) $display("FAIL reset_btn: got %b want 1", btn); else pass_cnt++;
        check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (press_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", press_cnt); else pass_cnt++;
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (btn !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || press_cnt !== 8'd0)
                bad++;
        end
        check_cnt++; if (bad !== 0) $display("FAIL idle_1000: got %0d bad cycles want 0", bad); else pass_cnt++;
        $display("idle 1000 cycles bad=%0d", bad);
    endtask

    task automatic test_no_bounce();
        meas_t m;
        run_press(300, 1'b0, m);
        check_cnt++; if (m.ready_at_issue !== 1'b1) $display("FAIL nb_ready_issue: got %b want 1", m.ready_at_issue); else pass_cnt++;
        check_cnt++; if (m.first_btn !== 1'b0) $display("FAIL nb_first_btn: got %b want 0", m.first_btn); else pass_cnt++;
        check_cnt++; if (m.first_busy !== 1'b1) $display("FAIL nb_first_busy: got %b want 1", m.first_busy); else pass_cnt++;
        check_cnt++; if (m.first_ready !== 1'b0) $display("FAIL nb_first_ready: got %b want 0", m.first_ready); else pass_cnt++;
        check_cnt++; if (m.total !== 300 + GAP) $display("FAIL nb_total: got %0d want %0d", m.total, 300 + GAP); else pass_cnt++;
        check_cnt++; if (m.low !== 300) $display("FAIL nb_low: got %0d want 300", m.low); else pass_cnt++;
        check_cnt++; if (m.max_run !== 300) $display("FAIL nb_run: got %0d want 300", m.max_run); else pass_cnt++;
        check_cnt++; if (m.falls_early + m.falls_late !== 1) $display("FAIL nb_falls: got %0d want 1", m.falls_early + m.falls_late); else pass_cnt++;
        check_cnt++; if (m.done_busy !== 1'b0) $display("FAIL nb_done_busy: got %b want 0", m.done_busy); else pass_cnt++;
        check_cnt++; if (m.done_cnt !== 1) $display("FAIL nb_cnt: got %0d want 1", m.done_cnt); else pass_cnt++;
        check_cnt++; if (m.done_after !== 1'b0) $display("FAIL nb_done_width: got %b want 0", m.done_after); else pass_cnt++;
    endtask

    task automatic test_bounce();
        meas_t m;
        run_press(300, 1'b1, m);
        check_cnt++; if (m.first_btn !== 1'b0) $display("FAIL b_first_btn: got %b want 0", m.first_btn); else pass_cnt++;
        check_cnt++; if (m.total !== 4 * BN * BC + 300 + GAP) $display("FAIL b_total: got %0d want %0d", m.total, 4 * BN * BC + 300 + GAP); else pass_cnt++;
        check_cnt++; if (m.low !== 2 * BN * BC + 300) $display("FAIL b_low: got %0d want %0d", m.low, 2 * BN * BC + 300); else pass_cnt++;
        check_cnt++; if (m.max_run !== 300) $display("FAIL b_run: got %0d want 300", m.max_run); else pass_cnt++;
        check_cnt++; if (m.short_runs !== 2 * BN) $display("FAIL b_short_runs: got %0d want %0d", m.short_runs, 2 * BN); else pass_cnt++;
        check_cnt++; if (m.falls_early !== BN + 1) $display("FAIL b_press_falls: got %0d want %0d", m.falls_early, BN + 1); else pass_cnt++;
        check_cnt++; if (m.falls_late !== BN) $display("FAIL b_release_falls: got %0d want %0d", m.falls_late, BN); else pass_cnt++;
        check_cnt++; if (m.done_cnt !== 2) $display("FAIL b_cnt: got %0d want 2", m.done_cnt); else pass_cnt++;
    endtask

    task automatic test_debouncer();
        meas_t m;
        do_reset();
        db_clr = 1'b1;
        @(negedge clk);
        db_clr = 1'b0;
        for (int i = 0; i < 5; i++) run_press(300, 1'b1, m);
        repeat (10) @(negedge clk);
        check_cnt++; if (led !== 5) $display("FAIL db_led: got %0d want 5", led); else pass_cnt++;
        check_cnt++; if (press_cnt !== 8'd5) $display("FAIL db_cnt: got %0d want 5", press_cnt); else pass_cnt++;
    endtask

    task automatic test_hold_zero_wrap();
        int dones, lows, t, last_done, bad_period, bad_restart, bad_ready;
        bit pend;
        do_reset();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_hold = '0;
        cmd_bounce = 1'b0;
        dones = 0; lows = 0; t = 0; last_done = -1;
        bad_period = 0; bad_restart = 0; bad_ready = 0; pend = 1'b0;
        while (dones < 256 && t < 256 * (GAP + 2) + 50) begin
            @(negedge clk);
            t++;
            if (pend) begin
                if (btn !== 1'b0) bad_restart++;
                pend = 1'b0;
            end
            if (btn === 1'b0) lows++;
            if (done === 1'b1) begin
                dones++;
                if (cmd_ready !== 1'b1) bad_ready++;
                if (last_done >= 0 && t - last_done != GAP + 2) bad_period++;
                last_done = t;
                pend = 1'b1;
                if (dones == 256) cmd_valid = 1'b0;
                $display("b2b press %0d done at cycle %0d cnt=%0d", dones, t, press_cnt);
            end
        end
        check_cnt++; if (dones !== 256) $display("FAIL wrap_dones: got %0d want 256", dones); else pass_cnt++;
        check_cnt++; if (lows !== 256) $display("FAIL wrap_low_cycles: got %0d want 256", lows); else pass_cnt++;
        check_cnt++; if (press_cnt !== 8'd0) $display("FAIL wrap_cnt: got %0d want 0", press_cnt); else pass_cnt++;
        check_cnt++; if (bad_period !== 0) $display("FAIL wrap_period: got %0d bad want 0", bad_period); else pass_cnt++;
        check_cnt++; if (bad_restart !== 0) $display("FAIL wrap_restart: got %0d bad want 0", bad_restart); else pass_cnt++;
        check_cnt++; if (bad_ready !== 0) $display("FAIL wrap_ready_in_done: got %0d bad want 0", bad_ready); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (btn !== 1'b1 || busy !== 1'b0) $display("FAIL wrap_stop: got btn=%b busy=%b want 1/0", btn, busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        meas_t m;
        int dones, lows;
        run_press(0, 1'b0, m);
        check_cnt++; if (m.done_cnt !== 1) $display("FAIL mid_pre_cnt: got %0d want 1", m.done_cnt); else pass_cnt++;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_hold = HOLD_W'(300);
        cmd_bounce = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (100) @(negedge clk);
        check_cnt++; if (btn !== 1'b0 || busy !== 1'b1) $display("FAIL mid_in_hold: got btn=%b busy=%b want 0/1", btn, busy); else pass_cnt++;
        rstn = 1'b0;
        @(negedge clk);
        check_cnt++; if (btn !== 1'b1) $display("FAIL mid_rst_btn: got %b want 1", btn); else pass_cnt++;
        check_cnt++; if (press_cnt !== 8'd0) $display("FAIL mid_rst_cnt: got %0d want 0", press_cnt); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL mid_rst_idle: got busy=%b ready=%b want 0/1", busy, cmd_ready); else pass_cnt++;
        rstn = 1'b1;
        dones = 0;
        lows = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (btn !== 1'b1) lows++;
        end
        check_cnt++; if (dones !== 0 || lows !== 0) $display("FAIL mid_no_done: got done=%0d low=%0d want 0/0", dones, lows); else pass_cnt++;
        run_press(10, 1'b0, m);
        check_cnt++; if (m.total !== 10 + GAP) $display("FAIL mid_after_total: got %0d want %0d", m.total, 10 + GAP); else pass_cnt++;
        check_cnt++; if (m.low !== 10) $display("FAIL mid_after_low: got %0d want 10", m.low); else pass_cnt++;
        check_cnt++; if (m.done_cnt !== 1) $display("FAIL mid_after_cnt: got %0d want 1", m.done_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_no_bounce();
        test_bounce();
        test_debouncer();
        test_hold_zero_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached after %0d/%0d checks", pass_cnt, check_cnt);
        $fatal(1, "watchdog");
    end

endmodule
